if_id_stage: RTL and testbench
==============================

# if_id_stage

Pipeline register between instruction fetch and instruction decode in the five-stage DLX-style pipeline. Captures each fetched instruction word and its PC+4, buffers up to two instructions so fetch can run at full rate against a stalling decode stage, and pre-splits the standard DLX fields for decode. Flush discards everything in flight (taken jump/branch redirect) and presents a NOP bubble downstream.

## Interface

- NopInstr, 32'h54000000, instruction word presented on out_instr whenever out_valid=0
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  fetch presents a valid instruction this cycle
- in_ready  output  1  stage can accept; registered, equals !skid_valid
- in_instr  input  [0:31]  fetched instruction, bit 0 = MSB
- in_pc_plus4  input  [0:31]  PC+4 of the fetched instruction
- flush  input  1  discard all held and incoming instructions
- out_valid  output  1  out_* hold a valid instruction
- out_ready  input  1  decode consumes the head entry this cycle
- out_instr  output  [0:31]  head instruction, or NopInstr when empty
- out_pc_plus4  output  [0:31]  head PC+4, 0 when empty
- out_opcode  output  [0:5]  out_instr[0:5]
- out_rs1  output  [0:4]  out_instr[6:10]
- out_rs2  output  [0:4]  out_instr[11:15]
- out_rd  output  [0:4]  out_instr[16:20]
- out_func  output  [0:5]  out_instr[26:31]
- out_imm16  output  [0:31]  out_instr[16:31] sign-extended from bit 16

## Operation

- Storage: main entry (main_valid, main_instr, main_pc) and skid entry (skid_valid, skid_instr, skid_pc). out_* driven from main; out_valid = main_valid.
- Accept = in_valid & in_ready & !flush. Pop = main_valid & out_ready & !flush.
- State (main_valid, skid_valid): EMPTY (0,0), ONE (1,0), FULL (1,1); (0,1) unreachable.
- EMPTY: accept -> ONE, data into main.
- ONE: accept & pop -> ONE, main replaced by input. Accept only -> FULL, input into skid. Pop only -> EMPTY.
- FULL: in_ready=0, no accept. Pop -> ONE, skid moves to main, skid cleared.
- Flush (any state): next state EMPTY; in_valid that cycle ignored; out_ready that cycle ignored (no pop counted).
- Reset: same as flush; reset takes priority over flush and all handshakes.
- Data registers of invalid entries are don't-care internally; outputs must still show NopInstr / 0 when out_valid=0.
- Field outputs purely combinational from out_instr; out_imm16[0:15] = out_instr[16].
- Ordering strictly FIFO; no instruction duplicated or dropped except by flush/reset.

## Timing

- Reset values: out_valid=0, in_ready=1, out_instr=NopInstr, out_pc_plus4=0, out_opcode=6'h15, counters (if enabled) 0.
- Latency: instruction accepted in cycle N appears on out_* with out_valid=1 in cycle N+1 when stage was EMPTY or ONE-with-pop.
- Throughput: one instruction/cycle sustained while out_ready=1.
- in_ready is a register output; no combinational path from out_ready or flush to in_ready.
- After flush in cycle N: out_valid=0 and in_ready=1 in cycle N+1; first post-flush accept possible in N+1, visible N+2.
- Decode stall (out_ready=0): out_* stable until pop; at most one further instruction accepted before in_ready drops.

## Configuration

- IFID_PERF_CNT_EN defined: adds outputs stall_cycles [0:31] (increments each cycle out_valid & !out_ready & !flush) and flush_count [0:31] (increments each cycle flush=1 with main_valid|skid_valid); both wrap at 2^32, cleared by reset only.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan

- Reset held 2 cycles, then released -> out_valid=0, in_ready=1, out_instr=32'h54000000, out_pc_plus4=0.
- Stream A,B,C (PC+4 = 4,8,12) with out_ready=1 -> each appears exactly one cycle after acceptance, in order, no gaps.
- Accept A, B with out_ready=0 -> in_ready=0 after B, out_instr=A held; raise out_ready -> A, then B on next cycle, in_ready returns to 1.
- FULL state, assert flush with in_valid=1 (instr D) -> next cycle out_valid=0, in_ready=1, D never appears.
- Present 32'h8C22FFFC -> out_opcode=6'h23, out_rs1=1, out_rs2=2, out_imm16=32'hFFFFFFFC.
- With IFID_PERF_CNT_EN: hold out_valid with out_ready=0 for 5 cycles, then one flush -> stall_cycles=5, flush_count=1.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: two-entry (main + skid) buffer between fetch and decode
// with flush-to-bubble and pre-split DLX fields. Optional IFID_PERF_CNT_EN adds perf counters.
module if_id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:31] in_instr,
  input  logic [0:31] in_pc_plus4,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:31] out_instr,
  output logic [0:31] out_pc_plus4,
  output logic [0:5]  out_opcode,
  output logic [0:4]  out_rs1,
  output logic [0:4]  out_rs2,
  output logic [0:4]  out_rd,
  output logic [0:5]  out_func,
  output logic [0:31] out_imm16,
  output logic [1:0]  fsm_state
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [0:31] stall_cycles,
  output logic [0:31] flush_count
`endif
);

  localparam logic [0:31] NopInstr = 32'h54000000;

  // State is the pair {main_valid, skid_valid}; 2'b01 cannot occur.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] FULL  = 2'b11;

  logic        main_valid;
  logic        skid_valid;
  logic [0:31] main_instr;
  logic [0:31] main_pc;
  logic [0:31] skid_instr;
  logic [0:31] skid_pc;
  logic        accept;
  logic        pop;

  // Handshake: a transfer happens on a cycle where valid and ready are both high and
  // flush is low; ready never depends combinationally on the partner's valid.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid & in_ready & !flush;
  assign pop       = main_valid & out_ready & !flush;
  assign fsm_state = {main_valid, skid_valid};

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (fsm_state)
        EMPTY: begin
          if (accept) begin
            main_valid <= 1'b1;
            main_instr <= in_instr;
            main_pc    <= in_pc_plus4;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_instr <= in_instr;
            main_pc    <= in_pc_plus4;
          end else if (accept) begin
            skid_valid <= 1'b1;
            skid_instr <= in_instr;
            skid_pc    <= in_pc_plus4;
          end else if (pop) begin
            main_valid <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            main_instr <= skid_instr;
            main_pc    <= skid_pc;
            skid_valid <= 1'b0;
          end
        end
        default: begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  // Invalid entries are masked so decode always sees a clean bubble.
  assign out_valid    = main_valid;
  assign out_instr    = main_valid ? main_instr : NopInstr;
  assign out_pc_plus4 = main_valid ? main_pc : 32'h0;

  assign out_opcode = out_instr[0:5];
  assign out_rs1    = out_instr[6:10];
  assign out_rs2    = out_instr[11:15];
  assign out_rd     = out_instr[16:20];
  assign out_func   = out_instr[26:31];
  assign out_imm16  = {{16{out_instr[16]}}, out_instr[16:31]};

`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'h0;
      flush_count  <= 32'h0;
    end else begin
      if (main_valid && !out_ready && !flush)
        stall_cycles <= stall_cycles + 32'h1;
      if (flush && (main_valid || skid_valid))
        flush_count <= flush_count + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: stimulus pushes expected entries into a queue,
// a negedge monitor pops and compares whenever decode takes the head.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h54000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] in_instr;
  logic [0:31] in_pc_plus4;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [0:31] out_instr;
  logic [0:31] out_pc_plus4;
  logic [0:5]  out_opcode;
  logic [0:4]  out_rs1;
  logic [0:4]  out_rs2;
  logic [0:4]  out_rd;
  logic [0:5]  out_func;
  logic [0:31] out_imm16;
  logic [1:0]  fsm_state;
`ifdef IFID_PERF_CNT_EN
  logic [0:31] stall_cycles;
  logic [0:31] flush_count;
`endif

  if_id_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc_plus4(in_pc_plus4), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc_plus4(out_pc_plus4), .out_opcode(out_opcode), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_func(out_func),
    .out_imm16(out_imm16), .fsm_state(fsm_state)
`ifdef IFID_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          occ = 0;
  logic        chk_en = 1'b0;
  logic        exp_out_valid = 1'b0;
  logic        exp_in_ready = 1'b1;
  logic [31:0] stall_m = 0, flush_m = 0, stall_vis = 0, flush_vis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of capacity two that empties on flush/reset.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rst);
    bit pop_m, acc_m;
    @(posedge clk); #1;
    reset = rst; in_valid = v; in_instr = ins; in_pc_plus4 = pc;
    out_ready = ordy; flush = fl;
    chk_en = !rst;
    exp_out_valid = (occ > 0);
    exp_in_ready  = (occ < 2);
    stall_vis = stall_m;
    flush_vis = flush_m;
    if (rst) begin
      occ = 0; stall_m = 0; flush_m = 0;
    end else if (fl) begin
      if (occ > 0) flush_m++;
      occ = 0;
    end else begin
      if (occ > 0 && !ordy) stall_m++;
      pop_m = (occ > 0) && ordy;
      acc_m = v && (occ < 2);
      if (acc_m) exp_q.push_back({ins, pc});
      occ = occ - int'(pop_m) + int'(acc_m);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [31:0] e_ins, e_pc, a_ins;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
      end else if (chk_en) begin
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_in_ready});
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_out_valid});
        if (exp_out_valid && exp_q.size() > 0) begin
          e_ins = exp_q[0][63:32];
          e_pc  = exp_q[0][31:0];
        end else begin
          e_ins = NOP;
          e_pc  = 32'h0;
        end
        a_ins = out_instr;
        chk("out_instr", a_ins, e_ins);
        chk("out_pc_plus4", out_pc_plus4, e_pc);
        chk("out_opcode", 32'(out_opcode), 32'(e_ins >> 26));
        chk("out_rs1", 32'(out_rs1), (e_ins >> 21) % 32);
        chk("out_rs2", 32'(out_rs2), (e_ins >> 16) % 32);
        chk("out_rd", 32'(out_rd), (e_ins >> 11) % 32);
        chk("out_func", 32'(out_func), e_ins % 64);
        chk("out_imm16", out_imm16,
            (e_ins % 65536 >= 32768) ? (e_ins % 65536) + 32'hFFFF0000 : e_ins % 65536);
`ifdef IFID_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, stall_vis);
        chk("flush_count", flush_count, flush_vis);
`endif
        if (flush) exp_q.delete();
        else if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pc;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc_plus4 = '0;
    out_ready = 1'b0; flush = 1'b0;

    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);   // reset values checked here

    // Streaming at full rate
    drive(1, 32'h20010001, 4, 1, 0, 0);
    drive(1, 32'h20020002, 8, 1, 0, 0);
    drive(1, 32'h20030003, 12, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);

    // Decode stall fills main then skid
    drive(1, 32'hA1A1A1A1, 16, 0, 0, 0);
    drive(1, 32'hB2B2B2B2, 20, 0, 0, 0);
    drive(1, 32'hDEADBEEF, 24, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);

    // Flush from FULL with an incoming instruction
    drive(1, 32'h11111111, 28, 0, 0, 0);
    drive(1, 32'h22222222, 32, 0, 0, 0);
    drive(1, 32'hDDDDDDDD, 36, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 32'h33333333, 40, 1, 0, 0);

    // Field decode with negative immediate
    drive(1, 32'h8C22FFFC, 44, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);

    // Stall five cycles then flush
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 32'h0BADF00D, 48, 0, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
`ifdef IFID_PERF_CNT_EN
    @(negedge clk); #1;
    chk("stall_cycles_directed", stall_cycles, 32'd5);
    chk("flush_count_directed", flush_count, 32'd1);
`endif

    // Randomised traffic
    pc = 32'd100;
    for (int i = 0; i < 400; i++) begin
      pc = pc + 4;
      drive(1'($urandom_range(0, 3) != 0), $urandom, pc,
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0), 1'b0);
    end

    // Drain and confirm nothing stuck or lost
    repeat (4) drive(0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
